// File: rtl/move_collector_if.sv
// Square-array bus and move stream between move_collector, the 64 square units and the search logic.
// master = collector side, slave = squares + consumer side.
interface move_collector_if #(
  parameter int NSQ = 64,
  parameter int MVW = 19,
  parameter int DW  = 160
);
  localparam int IW = $clog2(NSQ);

  logic [NSQ-1:0] sq_done;
  logic [NSQ-1:0] sq_empty;
  logic [DW-1:0]  sq_data;
  logic [IW-1:0]  sq_sel;
  logic [NSQ-1:0] sq_rden;
  logic           sq_reset;
  logic           mv_valid;
  logic           mv_ready;
  logic [MVW-1:0] mv_data;

  modport master (
    input  sq_done, sq_empty, sq_data, mv_ready,
    output sq_sel, sq_rden, sq_reset, mv_valid, mv_data
  );

  modport slave (
    output sq_done, sq_empty, sq_data, mv_ready,
    input  sq_sel, sq_rden, sq_reset, mv_valid, mv_data
  );
endinterface

// File: rtl/move_collector.sv
// Runs one move-generation pass: resets the squares, waits for done (with timeout), drains every FIFO
// and streams the valid moves one per cycle; a move is held in EMIT until mv_ready, no FIFO read while stalled.
module move_collector #(
  parameter int NSQ     = 64,
  parameter int MVW     = 19,
  parameter int SLOTS   = 8,
  parameter int DW      = 160,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  move_collector_if.master bus,
  output logic [10:0]      move_count,
  output logic             busy,
  output logic             done,
  output logic             timeout
);
  localparam int IW = $clog2(NSQ);
  localparam int SW = $clog2(SLOTS);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int WW = SLOTS * MVW;

  typedef enum logic [2:0] {
    S_IDLE, S_RST, S_WAIT, S_SCAN, S_READ, S_EMIT, S_FIN
  } state_t;

  state_t         state, state_nx;
  logic [IW-1:0]  idx, idx_nx;
  logic [SW-1:0]  slot, slot_nx;
  logic [TW-1:0]  timer, timer_nx;
  logic [10:0]    count_nx;
  logic           timeout_nx;
  logic [WW-1:0]  word_r, word_nx;
  logic [MVW-1:0] cur_mv;
  logic [NSQ-1:0] rden_c;
  logic           valid_c;
  logic           advance;
  logic           unused_data;

  assign cur_mv      = word_r[int'(slot)*MVW +: MVW];
  assign unused_data = ^bus.sq_data[DW-1:WW];

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      idx        <= '0;
      slot       <= '0;
      timer      <= '0;
      move_count <= '0;
      timeout    <= 1'b0;
      word_r     <= '0;
    end else begin
      state      <= state_nx;
      idx        <= idx_nx;
      slot       <= slot_nx;
      timer      <= timer_nx;
      move_count <= count_nx;
      timeout    <= timeout_nx;
      word_r     <= word_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    idx_nx     = idx;
    slot_nx    = slot;
    timer_nx   = timer;
    count_nx   = move_count;
    timeout_nx = timeout;
    word_nx    = word_r;
    rden_c     = '0;
    valid_c    = 1'b0;
    advance    = 1'b0;

    case (state)
      S_IDLE: begin
        if (start) begin
          state_nx   = S_RST;
          count_nx   = '0;
          timeout_nx = 1'b0;
          idx_nx     = '0;
        end
      end
      S_RST: begin
        state_nx = S_WAIT;
        timer_nx = '0;
      end
      S_WAIT: begin
        // timer==0 marks the first WAIT cycle, where done bits may be stale from the last pass
        if ((timer != '0) && (&bus.sq_done)) begin
          state_nx = S_SCAN;
        end else if (timer == TW'(TIMEOUT - 1)) begin
          state_nx   = S_SCAN;
          timeout_nx = 1'b1;
        end else begin
          timer_nx = timer + 1'b1;
        end
      end
      S_SCAN: begin
        if (!bus.sq_empty[idx]) begin
          rden_c[idx] = 1'b1;
          state_nx    = S_READ;
        end else if (idx == IW'(NSQ - 1)) begin
          state_nx = S_FIN;
        end else begin
          idx_nx = idx + 1'b1;
        end
      end
      S_READ: begin
        word_nx  = bus.sq_data[WW-1:0];
        slot_nx  = '0;
        state_nx = S_EMIT;
      end
      S_EMIT: begin
        if (cur_mv[MVW-1]) begin
          advance = 1'b1;
        end else begin
          valid_c = 1'b1;
          if (bus.mv_ready) begin
            advance = 1'b1;
            if (move_count != '1) count_nx = move_count + 1'b1;
          end
        end
        // back to SCAN on the same idx so the square is re-checked until its FIFO is empty
        if (advance) begin
          if (slot == SW'(SLOTS - 1)) state_nx = S_SCAN;
          else                        slot_nx  = slot + 1'b1;
        end
      end
      S_FIN:   state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  assign bus.sq_sel   = idx;
  assign bus.sq_rden  = reset ? '0 : rden_c;
  assign bus.sq_reset = reset | (state == S_RST);
  assign bus.mv_valid = valid_c & ~reset;
  assign bus.mv_data  = (valid_c & ~reset) ? cur_mv : '0;
  assign busy         = (state != S_IDLE) & ~reset;
  assign done         = (state == S_FIN) & ~reset;
endmodule

// File: tb/tb_move_collector.sv
// Directed bench for move_collector: square array modelled as per-square word queues,
// expected move order derived from the queued words, checked every cycle.
module tb_move_collector;
  localparam int NSQ = 64;
  localparam int MVW = 19;
  localparam int SLOTS = 8;
  localparam int DW = 160;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        mv_ready = 1'b1;
  logic [10:0] move_count;
  logic        busy, done, timeout;

  move_collector_if ifc ();

  move_collector dut (
    .clk(clk), .reset(reset), .start(start), .bus(ifc),
    .move_count(move_count), .busy(busy), .done(done), .timeout(timeout)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int rst_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // ---------------- square array model ----------------
  logic [DW-1:0]  pending [NSQ][$];
  logic [DW-1:0]  fifo    [NSQ][$];
  logic [DW-1:0]  q_reg   [NSQ];
  logic [NSQ-1:0] stuck   = '0;
  logic [NSQ-1:0] empty_r = '1;
  logic [NSQ-1:0] done_r  = '0;
  int             done_delay = 3;
  int             dcnt = 0;
  bit             armed = 1'b0;

  assign ifc.sq_empty = empty_r;
  assign ifc.sq_done  = done_r;
  assign ifc.sq_data  = q_reg[ifc.sq_sel];
  assign ifc.mv_ready = mv_ready;

  always @(posedge clk) begin
    logic [NSQ-1:0] e;
    if (ifc.sq_reset) begin
      for (int i = 0; i < NSQ; i++) begin
        fifo[i].delete();
        q_reg[i] <= '0;
      end
      armed = 1'b1;
      dcnt  = 0;
    end else begin
      if (armed) begin
        for (int i = 0; i < NSQ; i++) fifo[i] = pending[i];
        armed = 1'b0;
      end
      for (int i = 0; i < NSQ; i++)
        if (ifc.sq_rden[i] && fifo[i].size() > 0) q_reg[i] <= fifo[i].pop_front();
      if (dcnt < 100000) dcnt++;
    end
    for (int i = 0; i < NSQ; i++) e[i] = (fifo[i].size() == 0);
    empty_r <= e;
    done_r  <= (dcnt >= done_delay) ? ~stuck : '0;
  end

  // ---------------- expected-move model and per-cycle compare ----------------
  logic [MVW-1:0] exp_q [$];
  logic [MVW-1:0] got_q [$];
  int             model_cnt = 0;
  bit             hold = 1'b0;
  logic [MVW-1:0] hold_data = '0;

  always @(negedge clk) begin
    if (reset) begin
      model_cnt = 0;
      hold      = 1'b0;
    end else begin
      if (ifc.sq_reset) begin
        model_cnt = 0;
        rst_cyc   = cyc;
      end
      if (busy) check("move_count_track", 32'(move_count), 32'(model_cnt));
      if (|ifc.sq_rden) begin
        check("rden_onehot", 32'($onehot(ifc.sq_rden)), 32'd1);
        check("rden_to_empty", 32'(|(ifc.sq_rden & ifc.sq_empty)), 32'd0);
        check("rden_while_move", 32'(ifc.mv_valid), 32'd0);
        check("rden_busy", 32'(busy), 32'd1);
      end
      if (hold) begin
        check("hold_valid", 32'(ifc.mv_valid), 32'd1);
        check("hold_data", 32'(ifc.mv_data), 32'(hold_data));
      end
      if (ifc.mv_valid && ifc.mv_ready) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL extra_move got=%0h exp=none (cycle %0d)", ifc.mv_data, cyc);
        end else begin
          check("move_data", 32'(ifc.mv_data), 32'(exp_q.pop_front()));
        end
        got_q.push_back(ifc.mv_data);
        model_cnt++;
      end
      hold      = ifc.mv_valid && !ifc.mv_ready;
      hold_data = ifc.mv_data;
    end
  end

  // ---------------- helpers ----------------
  task automatic clear_pending();
    for (int i = 0; i < NSQ; i++) pending[i].delete();
  endtask

  task automatic start_pass();
    logic [DW-1:0]  w;
    logic [MVW-1:0] m;
    exp_q.delete();
    got_q.delete();
    for (int i = 0; i < NSQ; i++)
      for (int j = 0; j < pending[i].size(); j++) begin
        w = pending[i][j];
        for (int k = 0; k < SLOTS; k++) begin
          m = w[k*MVW +: MVW];
          if (!m[MVW-1]) exp_q.push_back(m);
        end
      end
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic finish_pass(input string name, input int exp_lat, input int exp_moves,
                             input logic exp_to);
    bit ok = 1'b0;
    int lat = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (done) begin
        ok  = 1'b1;
        lat = cyc - rst_cyc;
        break;
      end
    end
    if (!ok) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_done got=no-done exp=done-within-3000", name);
    end else begin
      check({name, "_latency"}, 32'(lat), 32'(exp_lat));
      check({name, "_move_count"}, 32'(move_count), 32'(exp_moves));
      check({name, "_timeout"}, 32'(timeout), 32'(exp_to));
      @(negedge clk);
      check({name, "_busy_after"}, 32'(busy), 32'd0);
      check({name, "_done_pulse"}, 32'(done), 32'd0);
      check({name, "_all_emitted"}, 32'(exp_q.size()), 32'd0);
    end
  endtask

  task automatic wait_valid(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk); #1;
      if (ifc.mv_valid) begin
        seen = 1'b1;
        break;
      end
    end
    check({name, "_valid_seen"}, 32'(seen), 32'd1);
  endtask

  // ---------------- directed tests ----------------
  initial begin
    logic [DW-1:0] w;
    logic [10:0]   mc;

    for (int i = 0; i < NSQ; i++) q_reg[i] = '0;
    clear_pending();

    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_mv_valid", 32'(ifc.mv_valid), 32'd0);
    check("rst_mv_data", 32'(ifc.mv_data), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_timeout", 32'(timeout), 32'd0);
    check("rst_move_count", 32'(move_count), 32'd0);
    check("rst_sq_rden", 32'(|ifc.sq_rden), 32'd0);
    check("rst_sq_sel", 32'(ifc.sq_sel), 32'd0);
    check("rst_sq_reset", 32'(ifc.sq_reset), 32'd1);
    reset = 1'b0;
    #1;
    check("idle_sq_reset", 32'(ifc.sq_reset), 32'd0);

    // 1: all FIFOs empty: RST + 4 WAIT + 64 SCAN cycles before FIN
    start_pass();
    finish_pass("t1", 69, 0, 1'b0);

    // 2: one word on square 12, two valid slots
    clear_pending();
    w = '0;
    for (int k = 0; k < SLOTS; k++) w[k*MVW +: MVW] = 19'h40000 | 19'(k);
    w[0*MVW +: MVW] = 19'h00A1C;
    w[3*MVW +: MVW] = 19'h01234;
    pending[12].push_back(w);
    start_pass();
    finish_pass("t2", 79, 2, 1'b0);
    check("t2_moves", 32'(got_q.size()), 32'd2);
    if (got_q.size() == 2) begin
      check("t2_first", 32'(got_q[0]), 32'h00A1C);
      check("t2_second", 32'(got_q[1]), 32'h01234);
    end

    // 3: two words on square 0, one on square 63, every slot valid
    clear_pending();
    for (int n = 0; n < 3; n++) begin
      w = '0;
      for (int k = 0; k < SLOTS; k++) w[k*MVW +: MVW] = 19'($urandom) & 19'h3FFFF;
      if (n < 2) pending[0].push_back(w);
      else       pending[63].push_back(w);
    end
    start_pass();
    finish_pass("t3", 99, 24, 1'b0);
    check("t3_moves", 32'(got_q.size()), 32'd24);

    // 4: consumer stalls 10 cycles on the first move
    clear_pending();
    w = '0;
    for (int k = 0; k < SLOTS; k++) w[k*MVW +: MVW] = 19'h00100 + 19'(k);
    pending[20].push_back(w);
    start_pass();
    wait_valid("t4");
    mv_ready = 1'b0;
    mc = move_count;
    check("t4_count_before", 32'(mc), 32'd0);
    repeat (10) begin
      @(posedge clk); #1;
    end
    check("t4_stall_count", 32'(move_count), 32'(mc));
    check("t4_stall_valid", 32'(ifc.mv_valid), 32'd1);
    check("t4_stall_data", 32'(ifc.mv_data), 32'h00100);
    mv_ready = 1'b1;
    finish_pass("t4", 89, 8, 1'b0);

    // 5: square 5 never done -> 255 WAIT cycles; a start while busy is ignored
    clear_pending();
    stuck[5] = 1'b1;
    start_pass();
    repeat (20) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    finish_pass("t5", 320, 0, 1'b1);
    stuck = '0;

    // 6: reset during EMIT, then a clean pass
    clear_pending();
    w = '0;
    for (int k = 0; k < SLOTS; k++) w[k*MVW +: MVW] = 19'h02000 + 19'(k);
    pending[7].push_back(w);
    mv_ready = 1'b0;
    start_pass();
    wait_valid("t6");
    reset = 1'b1;
    #1;
    check("t6_sq_reset_in_reset", 32'(ifc.sq_reset), 32'd1);
    @(posedge clk); #1;
    check("t6_busy", 32'(busy), 32'd0);
    check("t6_mv_valid", 32'(ifc.mv_valid), 32'd0);
    check("t6_move_count", 32'(move_count), 32'd0);
    check("t6_timeout", 32'(timeout), 32'd0);
    check("t6_done", 32'(done), 32'd0);
    check("t6_rden", 32'(|ifc.sq_rden), 32'd0);
    reset = 1'b0;
    #1;
    check("t6_sq_reset_after", 32'(ifc.sq_reset), 32'd0);
    mv_ready = 1'b1;
    start_pass();
    finish_pass("t6", 79, 8, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
